lcd_seq: RTL and testbench

LCD command sequencer that sits directly downstream of the LCD register bank. It walks the bank's eight 24-bit entries by driving the bank's `sel_out` index. For each enabled entry it captures the {address, control, data} bytes and plays the entry onto an HD44780-compatible 8-bit parallel LCD bus, using programmable RS setup, E pulse width and post-write wait times. It reports progress on an 8-bit status byte, which the bank's `status` input consumes.

---
 rtl/lcd_seq.sv | 150 +++++++++++++++
 tb/tb_lcd_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_seq.sv
// Walks the LCD register bank entries and plays each enabled entry onto an
// HD44780-style 8-bit bus with programmable setup, strobe and wait times.
module lcd_seq #(
  parameter int SETUP      = 4,
  parameter int E_PULSE    = 12,
  parameter int SHORT_WAIT = 2000,
  parameter int LONG_WAIT  = 82000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [2:0] sel_out,
  input  logic [7:0] addr_in,
  input  logic [7:0] ctrl_in,
  input  logic [7:0] data_in,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_db,
  output logic       busy,
  output logic       done,
  output logic [7:0] status
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_SETUP, S_PULSE, S_HOLD, S_NEXT, S_DONE
  } state_t;

  localparam logic [19:0] SETUP_M1 = 20'(SETUP - 1);
  localparam logic [19:0] PULSE_M1 = 20'(E_PULSE - 1);
  localparam logic [19:0] SHORT_M1 = 20'(SHORT_WAIT - 1);
  localparam logic [19:0] LONG_M1  = 20'(LONG_WAIT - 1);

  state_t      state;
  logic [19:0] cnt;
  logic        prefix_ph;
  logic        pass_done;
  logic        rs_q, long_q, last_q;
  logic [7:0]  data_q;
  logic        unused_bits;

  function automatic logic [7:0] prefix_cmd(input logic [6:0] a);
    return {1'b1, a};
  endfunction

  assign unused_bits = ^{ctrl_in[6:4], addr_in[7]};
  assign lcd_rw = 1'b0;
  assign status = {busy, pass_done, 3'b000, sel_out};

  // Entry capture on the second FETCH cycle, once the bank's registered read has settled
  always_ff @(posedge clk) begin
    if (state == S_FETCH && cnt == 20'd0) begin
      rs_q   <= ctrl_in[1];
      long_q <= ctrl_in[2];
      last_q <= ctrl_in[7];
      data_q <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      prefix_ph <= 1'b0;
      pass_done <= 1'b0;
      sel_out   <= 3'd0;
      lcd_rs    <= 1'b0;
      lcd_e     <= 1'b0;
      lcd_db    <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_FETCH;
            cnt       <= 20'd1;
            sel_out   <= 3'd0;
            busy      <= 1'b1;
            pass_done <= 1'b0;
          end
        end
        S_FETCH: begin
          if (cnt != 20'd0) begin
            cnt <= cnt - 20'd1;
          end else if (ctrl_in[0]) begin
            // Bus values come straight from the bank here so they are stable from SETUP entry
            state     <= S_SETUP;
            cnt       <= SETUP_M1;
            prefix_ph <= ctrl_in[3];
            lcd_rs    <= ctrl_in[3] ? 1'b0 : ctrl_in[1];
            lcd_db    <= ctrl_in[3] ? prefix_cmd(addr_in[6:0]) : data_in;
          end else begin
            state <= S_NEXT;
          end
        end
        S_SETUP: begin
          if (cnt != 20'd0) begin
            cnt <= cnt - 20'd1;
          end else begin
            state <= S_PULSE;
            cnt   <= PULSE_M1;
            lcd_e <= 1'b1;
          end
        end
        S_PULSE: begin
          if (cnt != 20'd0) begin
            cnt <= cnt - 20'd1;
          end else begin
            state <= S_HOLD;
            lcd_e <= 1'b0;
            cnt   <= (!prefix_ph && long_q) ? LONG_M1 : SHORT_M1;
          end
        end
        S_HOLD: begin
          if (cnt != 20'd0) begin
            cnt <= cnt - 20'd1;
          end else if (prefix_ph) begin
            state     <= S_SETUP;
            cnt       <= SETUP_M1;
            prefix_ph <= 1'b0;
            lcd_rs    <= rs_q;
            lcd_db    <= data_q;
          end else begin
            state <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (last_q || sel_out == 3'd7) begin
            state     <= S_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            pass_done <= 1'b1;
          end else begin
            state   <= S_FETCH;
            cnt     <= 20'd1;
            sel_out <= sel_out + 3'd1;
          end
        end
        S_DONE: begin
          state   <= S_IDLE;
          sel_out <= 3'd0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_seq.sv
// Directed bench for lcd_seq with a registered bank model and hand-derived cycle timings.
module tb_lcd_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] sel_out;
  logic [7:0] addr_in, ctrl_in, data_in;
  logic       lcd_rs, lcd_rw, lcd_e, busy, done;
  logic [7:0] lcd_db, status;

  logic [7:0] addr_m [8];
  logic [7:0] ctrl_m [8];
  logic [7:0] data_m [8];

  int checks = 0;
  int failures = 0;

  // Pass observation, filled by watch_pass
  int         np, ndone, done_t, maxsel;
  int         p_t [16];
  int         p_len [16];
  logic       p_rs [16];
  logic [7:0] p_db [16];
  logic [2:0] p_sel [16];
  logic       done_busy, rs3;
  logic [7:0] done_status, db3, st1, st_after;
  logic [2:0] sel_after;

  lcd_seq #(.SETUP(2), .E_PULSE(3), .SHORT_WAIT(5), .LONG_WAIT(9)) dut (
    .clk(clk), .rst(rst), .start(start), .sel_out(sel_out),
    .addr_in(addr_in), .ctrl_in(ctrl_in), .data_in(data_in),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_db(lcd_db),
    .busy(busy), .done(done), .status(status)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    addr_in <= addr_m[sel_out];
    ctrl_in <= ctrl_m[sel_out];
    data_in <= data_m[sel_out];
  end

  task automatic load_bank(input logic [7:0] c_default);
    for (int i = 0; i < 8; i++) begin
      addr_m[i] = 8'h00; ctrl_m[i] = c_default; data_m[i] = 8'(8'h10 + i);
    end
  endtask

  // Cycle k = 0 is the cycle in which start is sampled; extra start high in [slo, shi].
  task automatic watch_pass(input int ncyc, input int slo, input int shi);
    logic eprev;
    np = 0; ndone = 0; done_t = -1; maxsel = 0; eprev = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (lcd_e && !eprev && np < 16) begin
        p_t[np] = k; p_len[np] = 0; p_rs[np] = lcd_rs; p_db[np] = lcd_db; p_sel[np] = sel_out;
        np++;
      end
      if (lcd_e && np > 0) p_len[np-1]++;
      if (done) begin ndone++; done_t = k; done_busy = busy; done_status = status; end
      if (int'(sel_out) > maxsel) maxsel = int'(sel_out);
      if (k == 1) st1 = status;
      if (k == 3) begin rs3 = lcd_rs; db3 = lcd_db; end
      if (done_t >= 0 && k == done_t + 1) begin st_after = status; sel_after = sel_out; end
      eprev = lcd_e;
      start = (k == 0) || (k >= slo && k <= shi);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    start = 1'b1;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ({lcd_e, lcd_rs, lcd_rw, busy, done} !== 5'b0 || lcd_db !== 8'h00 ||
          status !== 8'h00 || sel_out !== 3'd0) begin
        failures++;
        $display("FAIL reset_outputs cyc%0d: e=%b rs=%b rw=%b busy=%b done=%b db=%h status=%h sel=%0d, required all zero",
                 k, lcd_e, lcd_rs, lcd_rw, busy, done, lcd_db, status, sel_out);
      end
    end
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_command;
    load_bank(8'h00);
    addr_m[0] = 8'h00; ctrl_m[0] = 8'h81; data_m[0] = 8'h01;
    watch_pass(20, -1, -1);
    checks++;
    if (st1 !== 8'h80) begin failures++; $display("FAIL single_status_busy: got %h want 80", st1); end
    checks++;
    if (rs3 !== 1'b0 || db3 !== 8'h01) begin
      failures++; $display("FAIL single_bus_cycle3: rs=%b db=%h want rs=0 db=01", rs3, db3);
    end
    checks++;
    if (np !== 1 || p_t[0] !== 5 || p_len[0] !== 3) begin
      failures++; $display("FAIL single_pulse: n=%0d t=%0d len=%0d want n=1 t=5 len=3", np, p_t[0], p_len[0]);
    end
    checks++;
    if (ndone !== 1 || done_t !== 14 || done_busy !== 1'b0 || done_status !== 8'h40) begin
      failures++;
      $display("FAIL single_done: n=%0d t=%0d busy=%b status=%h want n=1 t=14 busy=0 status=40",
               ndone, done_t, done_busy, done_status);
    end
    checks++;
    if (lcd_rw !== 1'b0) begin failures++; $display("FAIL rw_const: got %b want 0", lcd_rw); end
  endtask

  task automatic test_prefix;
    load_bank(8'h00);
    addr_m[0] = 8'h45; ctrl_m[0] = 8'h8B; data_m[0] = 8'h41;
    watch_pass(30, -1, -1);
    checks++;
    if (np !== 2) begin failures++; $display("FAIL prefix_count: got %0d want 2", np); end
    checks++;
    if (p_t[0] !== 5 || p_rs[0] !== 1'b0 || p_db[0] !== 8'hC5) begin
      failures++; $display("FAIL prefix_cmd: t=%0d rs=%b db=%h want t=5 rs=0 db=C5", p_t[0], p_rs[0], p_db[0]);
    end
    checks++;
    if (p_t[1] !== 15 || p_rs[1] !== 1'b1 || p_db[1] !== 8'h41) begin
      failures++; $display("FAIL prefix_data: t=%0d rs=%b db=%h want t=15 rs=1 db=41", p_t[1], p_rs[1], p_db[1]);
    end
    checks++;
    if (done_t !== 24) begin failures++; $display("FAIL prefix_done: t=%0d want 24", done_t); end
  endtask

  task automatic test_skip_long_stop;
    load_bank(8'h01);
    ctrl_m[0] = 8'h00;
    ctrl_m[1] = 8'h05; data_m[1] = 8'h01;
    ctrl_m[2] = 8'h81; data_m[2] = 8'h33;
    watch_pass(45, -1, -1);
    checks++;
    if (np !== 2 || p_sel[0] !== 3'd1 || p_sel[1] !== 3'd2) begin
      failures++; $display("FAIL skip_pulses: n=%0d sel0=%0d sel1=%0d want n=2 sel 1,2", np, p_sel[0], p_sel[1]);
    end
    checks++;
    if (p_t[0] !== 8 || p_rs[0] !== 1'b0 || p_db[0] !== 8'h01) begin
      failures++; $display("FAIL skip_entry1: t=%0d rs=%b db=%h want t=8 rs=0 db=01", p_t[0], p_rs[0], p_db[0]);
    end
    checks++;
    if (p_t[1] !== 25 || p_db[1] !== 8'h33) begin
      failures++; $display("FAIL long_wait_spacing: t=%0d db=%h want t=25 db=33", p_t[1], p_db[1]);
    end
    checks++;
    if (done_t !== 34 || maxsel !== 2) begin
      failures++; $display("FAIL last_stop: done_t=%0d maxsel=%0d want 34 and 2", done_t, maxsel);
    end
  endtask

  task automatic test_full_walk;
    int bad;
    load_bank(8'h01);
    watch_pass(115, -1, -1);
    bad = 0;
    for (int i = 0; i < 8; i++)
      if (p_t[i] !== 5 + 13*i || p_sel[i] !== 3'(i) || p_db[i] !== 8'(8'h10 + i)) bad++;
    checks++;
    if (np !== 8 || bad !== 0) begin
      failures++; $display("FAIL walk_pulses: n=%0d bad=%0d want n=8 bad=0", np, bad);
    end
    checks++;
    if (done_t !== 105 || ndone !== 1) begin
      failures++; $display("FAIL walk_done: t=%0d n=%0d want t=105 n=1", done_t, ndone);
    end
    checks++;
    if (st_after !== 8'h40 || sel_after !== 3'd0) begin
      failures++; $display("FAIL walk_idle_status: status=%h sel=%0d want 40 and 0", st_after, sel_after);
    end
  endtask

  task automatic test_start_while_busy;
    load_bank(8'h00);
    ctrl_m[0] = 8'h81; data_m[0] = 8'h01;
    watch_pass(40, 3, 12);
    checks++;
    if (np !== 1 || ndone !== 1 || done_t !== 14) begin
      failures++; $display("FAIL busy_start_ignored: pulses=%0d dones=%0d t=%0d want 1 1 14", np, ndone, done_t);
    end
  endtask

  task automatic test_reset_mid_pulse;
    load_bank(8'h00);
    addr_m[0] = 8'h45; ctrl_m[0] = 8'h8B; data_m[0] = 8'h41;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      start = (k == 0);
    end
    checks++;
    if (lcd_e !== 1'b1) begin failures++; $display("FAIL rst_mid_e_before: e=%b want 1", lcd_e); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (lcd_e !== 1'b0 || busy !== 1'b0 || status !== 8'h00 || lcd_db !== 8'h00) begin
      failures++; $display("FAIL rst_mid_after: e=%b busy=%b status=%h db=%h want 0 0 00 00", lcd_e, busy, status, lcd_db);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (lcd_e !== 1'b0 || busy !== 1'b0) begin
        failures++; $display("FAIL rst_mid_idle: e=%b busy=%b want 0 0", lcd_e, busy);
      end
    end
    watch_pass(30, -1, -1);
    checks++;
    if (np !== 2 || p_t[0] !== 5 || p_db[0] !== 8'hC5 || p_sel[0] !== 3'd0 || done_t !== 24) begin
      failures++; $display("FAIL rst_replay: n=%0d t=%0d db=%h sel=%0d done=%0d want 2 5 C5 0 24",
                           np, p_t[0], p_db[0], p_sel[0], done_t);
    end
  endtask

  initial begin
    load_bank(8'h00);
    test_reset;
    test_single_command;
    test_prefix;
    test_skip_long_stop;
    test_full_walk;
    test_start_while_busy;
    test_reset_mid_pulse;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
